// File: rtl/burst_coalescer_pkg.sv
// Shared types and constants for the burst coalescer and its page-check helper.
package burst_coalescer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int AXI_MAX_LEN            = 255;
    localparam int DEFAULT_PAGE_BYTES_LOG = 12;

endpackage

// File: rtl/burst_coalescer_if.sv
// Beat-address FIFO read side plus burst-address and burst-length FIFO write sides.
interface burst_coalescer_if #(
    parameter int AddrWidth     = 64,
    parameter int BurstLenWidth = 8
);
    logic [AddrWidth-1:0]               addr_dout;
    logic                               addr_empty_n;
    logic                               addr_read;
    logic [BurstLenWidth+AddrWidth-1:0] addr_din;
    logic                               addr_full_n;
    logic                               addr_write;
    logic [BurstLenWidth-1:0]           burst_len_din;
    logic                               burst_len_full_n;
    logic                               burst_len_write;

    modport master (
        output addr_dout, addr_empty_n, addr_full_n, burst_len_full_n,
        input  addr_read, addr_din, addr_write, burst_len_din, burst_len_write
    );

    modport slave (
        input  addr_dout, addr_empty_n, addr_full_n, burst_len_full_n,
        output addr_read, addr_din, addr_write, burst_len_din, burst_len_write
    );
endinterface

// File: rtl/burst_coalescer_page_check.sv
// Contiguity and page-boundary test for the beat that would extend a pending burst.
module burst_page_check #(
    parameter int AddrWidth         = 64,
    parameter int DataWidthBytesLog = 6,
    parameter int BurstLenWidth     = 8,
    parameter int PageBytesLog      = 12
) (
    input  logic [AddrWidth-1:0]     base,
    input  logic [BurstLenWidth-1:0] len,
    input  logic [AddrWidth-1:0]     addr,
    input  logic                     addr_valid,
    output logic [AddrWidth-1:0]     next_addr,
    output logic                     contig,
    output logic                     page_ok
);

    logic [AddrWidth-1:0] beats_s;

    assign beats_s   = AddrWidth'(len) + AddrWidth'(1);
    assign next_addr = base + (beats_s << DataWidthBytesLog);
    assign contig    = addr_valid && (addr == next_addr);
    // Landing exactly on the boundary counts as leaving the page.
    assign page_ok   = (next_addr[AddrWidth-1:PageBytesLog] == base[AddrWidth-1:PageBytesLog]);

endmodule

// File: rtl/burst_coalescer.sv
// Merges contiguous beat addresses into page-bounded INCR bursts, pushing
// {len, base} and len together, with saturating burst/beat statistics.
module burst_coalescer
    import burst_coalescer_pkg::*;
#(
    parameter int AddrWidth         = 64,
    parameter int DataWidthBytesLog = 6,
    parameter int WaitTimeWidth     = 4,
    parameter int BurstLenWidth     = 8,
    parameter int PageBytesLog      = DEFAULT_PAGE_BYTES_LOG,
    parameter int StatWidth         = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WaitTimeWidth-1:0]  max_wait_time,
    input  logic [BurstLenWidth-1:0]  max_burst_len,
    input  logic                      flush,
    burst_coalescer_if.slave          bus,
    output logic                      idle,
    output logic [StatWidth-1:0]      num_bursts,
    output logic [StatWidth-1:0]      num_beats
);

    if (BurstLenWidth > $clog2(AXI_MAX_LEN + 1)) begin : g_len_width_check
        $error("BurstLenWidth exceeds the AXI length field");
    end

    state_t                   state_r;
    logic [AddrWidth-1:0]     base_r;
    logic [BurstLenWidth-1:0] len_r;
    logic [WaitTimeWidth-1:0] wait_r;

    // Only the write-path user of the checker needs the next address itself.
    logic [AddrWidth-1:0]     unused_next_addr_s;
    logic                     contig_s;
    logic                     page_ok_s;
    logic                     pop_s;
    logic                     push_s;
    logic                     extend_s;
    logic                     close_s;

    burst_page_check #(
        .AddrWidth         (AddrWidth),
        .DataWidthBytesLog (DataWidthBytesLog),
        .BurstLenWidth     (BurstLenWidth),
        .PageBytesLog      (PageBytesLog)
    ) u_page_check (
        .base       (base_r),
        .len        (len_r),
        .addr       (bus.addr_dout),
        .addr_valid (bus.addr_empty_n),
        .next_addr  (unused_next_addr_s),
        .contig     (contig_s),
        .page_ok    (page_ok_s)
    );

    // Per-state pop/push/extend/close decisions for the current cycle.
    always_comb begin
        pop_s    = 1'b0;
        push_s   = 1'b0;
        extend_s = 1'b0;
        close_s  = 1'b0;
        case (state_r)
            IDLE: begin
                pop_s = bus.addr_empty_n;
            end
            ACCUM: begin
                if (contig_s && page_ok_s && (len_r < max_burst_len) && !flush) begin
                    extend_s = 1'b1;
                    pop_s    = 1'b1;
                end else if (flush || bus.addr_empty_n || !page_ok_s ||
                             (len_r == max_burst_len) || (wait_r >= max_wait_time)) begin
                    close_s = 1'b1;
                end else begin
                    close_s = 1'b0;
                end
            end
            EMIT: begin
                // Both FIFOs must accept so the WLAST stream never drifts from the bursts.
                push_s = bus.addr_full_n && bus.burst_len_full_n;
                pop_s  = push_s && bus.addr_empty_n;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    assign bus.addr_read       = pop_s && !rst;
    assign bus.addr_write      = push_s;
    assign bus.burst_len_write = push_s;
    assign bus.addr_din        = {len_r, base_r};
    assign bus.burst_len_din   = len_r;
    assign idle                = (state_r == IDLE);

    // Burst-building state machine; a push with a waiting beat starts the next burst at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            base_r  <= {AddrWidth{1'b0}};
            len_r   <= {BurstLenWidth{1'b0}};
            wait_r  <= {WaitTimeWidth{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        base_r  <= bus.addr_dout;
                        len_r   <= {BurstLenWidth{1'b0}};
                        wait_r  <= {WaitTimeWidth{1'b0}};
                        state_r <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (extend_s) begin
                        len_r  <= len_r + BurstLenWidth'(1);
                        wait_r <= {WaitTimeWidth{1'b0}};
                    end else if (close_s) begin
                        state_r <= EMIT;
                    end else if (wait_r != {WaitTimeWidth{1'b1}}) begin
                        wait_r <= wait_r + WaitTimeWidth'(1);
                    end
                end
                EMIT: begin
                    if (push_s) begin
                        if (bus.addr_empty_n) begin
                            base_r  <= bus.addr_dout;
                            len_r   <= {BurstLenWidth{1'b0}};
                            wait_r  <= {WaitTimeWidth{1'b0}};
                            state_r <= ACCUM;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Saturating statistics on pops and pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_beats  <= {StatWidth{1'b0}};
            num_bursts <= {StatWidth{1'b0}};
        end else begin
            if (bus.addr_read && (num_beats != {StatWidth{1'b1}})) begin
                num_beats <= num_beats + StatWidth'(1);
            end
            if (push_s && (num_bursts != {StatWidth{1'b1}})) begin
                num_bursts <= num_bursts + StatWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_burst_coalescer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized address streams scored against a list-level burst grouping model.
module tb_burst_coalescer;

    typedef struct packed {
        logic [7:0]  len;
        logic [63:0] addr;
    } burst_t;

    typedef struct {
        int          mbl;
        int          mw;
        int          n;
        logic [63:0] a  [4];
        int          nb;
        logic [7:0]  el [4];
        logic [63:0] ea [4];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  max_wait_time = 4'd0;
    logic [7:0]  max_burst_len = 8'd0;
    logic        flush = 1'b0;
    logic        idle;
    logic [31:0] num_bursts;
    logic [31:0] num_beats;

    burst_coalescer_if #(.AddrWidth(64), .BurstLenWidth(8)) bus ();

    burst_coalescer dut (
        .clk           (clk),
        .rst           (rst),
        .max_wait_time (max_wait_time),
        .max_burst_len (max_burst_len),
        .flush         (flush),
        .bus           (bus),
        .idle          (idle),
        .num_bursts    (num_bursts),
        .num_beats     (num_beats)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] src_q [$];
    burst_t      got_q [$];
    logic        s_rd, s_wr, s_blw, s_idle, s_empty_n;
    logic [71:0] s_din;
    bit          rand_sink = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        bus.addr_empty_n = (src_q.size() > 0);
        bus.addr_dout    = (src_q.size() > 0) ? src_q[0] : 64'h0;
    endtask

    // One clock: sample handshakes at negedge, then update the source FIFO after the edge.
    task automatic cycle();
        @(negedge clk);
        s_rd      = bus.addr_read;
        s_wr      = bus.addr_write;
        s_blw     = bus.burst_len_write;
        s_idle    = idle;
        s_empty_n = bus.addr_empty_n;
        s_din     = bus.addr_din;
        if (s_wr || s_blw) check("write_pair", 72'(s_blw), 72'(s_wr));
        if (s_wr) begin
            check("len_stream", 72'(bus.burst_len_din), 72'(s_din[71:64]));
            got_q.push_back('{len: s_din[71:64], addr: s_din[63:0]});
            if (s_empty_n) check("zero_bubble", 72'(s_rd), 72'(1'b1));
        end
        @(posedge clk);
        #1;
        if (s_rd && src_q.size() > 0) void'(src_q.pop_front());
        drive_src();
        if (rand_sink) begin
            bus.addr_full_n      = ($urandom_range(0, 3) != 0);
            bus.burst_len_full_n = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        rand_sink = 1'b0;
        src_q.delete();
        drive_src();
        bus.addr_full_n = 1'b1;
        bus.burst_len_full_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        s_idle = 1'b0;
        while (!(src_q.size() == 0 && s_idle) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 72'(n), 72'(budget - 1));
    endtask

    task automatic compare_bursts(input string tag, input burst_t exp[$]);
        check({tag, "_count"}, 72'(got_q.size()), 72'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_len%0d", tag, i), 72'(got_q[i].len), 72'(exp[i].len));
            check($sformatf("%s_addr%0d", tag, i), 72'(got_q[i].addr), 72'(exp[i].addr));
        end
    endtask

    // Grouping rule: extend while the next address is exactly one beat further,
    // the burst has fewer than max+1 beats, and the new beat shares the base's 4 KB page.
    function automatic void model(input logic [63:0] a[$], input int mbl, output burst_t out[$]);
        int i = 0;
        out = {};
        while (i < a.size()) begin
            logic [63:0] base = a[i];
            int cnt = 1;
            i++;
            while (i < a.size() && cnt <= mbl && a[i] == base + 64'(cnt) * 64'd64 &&
                   (a[i] >> 12) == (base >> 12)) begin
                cnt++;
                i++;
            end
            out.push_back('{len: 8'(cnt - 1), addr: base});
        end
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs [6];
        burst_t exp_q [$];
        logic [63:0] addrs [$];

        vecs[0] = '{mbl:255, mw:3, n:4, a:'{64'h0, 64'h40, 64'h80, 64'hC0},
                    nb:1, el:'{8'd3, 8'd0, 8'd0, 8'd0}, ea:'{64'h0, 64'h0, 64'h0, 64'h0}};
        vecs[1] = '{mbl:255, mw:2, n:2, a:'{64'hFC0, 64'h1000, 64'h0, 64'h0},
                    nb:2, el:'{8'd0, 8'd0, 8'd0, 8'd0}, ea:'{64'hFC0, 64'h1000, 64'h0, 64'h0}};
        vecs[2] = '{mbl:1, mw:0, n:4, a:'{64'h0, 64'h40, 64'h80, 64'hC0},
                    nb:2, el:'{8'd1, 8'd1, 8'd0, 8'd0}, ea:'{64'h0, 64'h80, 64'h0, 64'h0}};
        vecs[3] = '{mbl:255, mw:0, n:2, a:'{64'h0, 64'h100, 64'h0, 64'h0},
                    nb:2, el:'{8'd0, 8'd0, 8'd0, 8'd0}, ea:'{64'h0, 64'h100, 64'h0, 64'h0}};
        vecs[4] = '{mbl:0, mw:1, n:2, a:'{64'h0, 64'h40, 64'h0, 64'h0},
                    nb:2, el:'{8'd0, 8'd0, 8'd0, 8'd0}, ea:'{64'h0, 64'h40, 64'h0, 64'h0}};
        vecs[5] = '{mbl:255, mw:5, n:3, a:'{64'hF80, 64'hFC0, 64'h1000, 64'h0},
                    nb:2, el:'{8'd1, 8'd0, 8'd0, 8'd0}, ea:'{64'hF80, 64'h1000, 64'h0, 64'h0}};

        drive_src();
        bus.addr_full_n = 1'b1;
        bus.burst_len_full_n = 1'b1;
        #2;
        check("rst_idle", 72'(idle), 72'(1'b1));
        check("rst_din", 72'(bus.addr_din), 72'(0));
        check("rst_len_din", 72'(bus.burst_len_din), 72'(0));
        check("rst_write", 72'({bus.addr_write, bus.burst_len_write, bus.addr_read}), 72'(0));
        check("rst_counters", 72'({num_beats, num_bursts}), 72'(0));

        // Directed vector table.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            max_burst_len = 8'(vecs[v].mbl);
            max_wait_time = 4'(vecs[v].mw);
            for (int i = 0; i < vecs[v].n; i++) src_q.push_back(vecs[v].a[i]);
            drive_src();
            drain($sformatf("vec%0d", v), 200);
            exp_q = {};
            for (int i = 0; i < vecs[v].nb; i++) exp_q.push_back('{len: vecs[v].el[i], addr: vecs[v].ea[i]});
            compare_bursts($sformatf("vec%0d", v), exp_q);
            check($sformatf("vec%0d_beats", v), 72'(num_beats), 72'(vecs[v].n));
            check($sformatf("vec%0d_bursts", v), 72'(num_bursts), 72'(vecs[v].nb));
        end

        // Flush cuts a pending burst short long before the idle timer would.
        do_reset();
        max_burst_len = 8'd255;
        max_wait_time = 4'd15;
        src_q.push_back(64'h0);
        src_q.push_back(64'h40);
        drive_src();
        repeat (4) cycle();
        check("flush_pre", 72'(got_q.size()), 72'(0));
        flush = 1'b1;
        repeat (2) cycle();
        flush = 1'b0;
        check("flush_push", 72'(got_q.size()), 72'(1));
        drain("flush", 50);
        compare_bursts("flush", '{'{len: 8'd1, addr: 64'h0}});

        // Backpressure: five stalled EMIT cycles, then a single push.
        do_reset();
        max_burst_len = 8'd255;
        max_wait_time = 4'd0;
        bus.addr_full_n = 1'b0;
        src_q.push_back(64'h1C0);
        src_q.push_back(64'h400);
        drive_src();
        repeat (2) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("stall%0d_din", i), s_din, {8'd0, 64'h1C0});
            check($sformatf("stall%0d_rw", i), 72'({s_rd, s_wr}), 72'(0));
        end
        bus.addr_full_n = 1'b1;
        cycle();
        check("stall_release", 72'(got_q.size()), 72'(1));
        drain("stall", 50);
        compare_bursts("stall", '{'{len: 8'd0, addr: 64'h1C0}, '{len: 8'd0, addr: 64'h400}});

        // Reset mid-burst discards the pending burst and clears counters at once.
        do_reset();
        max_burst_len = 8'd255;
        max_wait_time = 4'd15;
        src_q.push_back(64'h0);
        src_q.push_back(64'h40);
        drive_src();
        repeat (3) cycle();
        check("pre_rst_beats", 72'(num_beats), 72'(2));
        rst = 1'b1;
        #1;
        check("mid_rst_idle", 72'(idle), 72'(1'b1));
        check("mid_rst_counters", 72'({num_beats, num_bursts}), 72'(0));
        src_q.push_back(64'h80);
        drive_src();
        #1;
        check("mid_rst_read", 72'(bus.addr_read), 72'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        src_q.delete();
        drive_src();
        rst = 1'b0;
        repeat (10) cycle();
        check("mid_rst_nopush", 72'(got_q.size()), 72'(0));
        check("mid_rst_bursts", 72'(num_bursts), 72'(0));

        // Randomized streams against the grouping model, with random sink backpressure.
        for (int r = 0; r < 20; r++) begin
            logic [63:0] prev;
            int mbl;
            do_reset();
            case (r % 4)
                0:       mbl = 0;
                1:       mbl = 1;
                2:       mbl = 3;
                default: mbl = int'($urandom_range(0, 255));
            endcase
            max_burst_len = 8'(mbl);
            max_wait_time = 4'($urandom_range(0, 15));
            addrs = {};
            prev = (64'($urandom_range(0, 15)) << 12) + (64'($urandom_range(0, 63)) << 6);
            for (int i = 0; i < 40; i++) begin
                int k = int'($urandom_range(0, 9));
                if (i > 0) begin
                    if (k < 7)       prev = prev + 64'h40;
                    else if (k == 8) prev = (64'($urandom_range(0, 15)) << 12) + 64'hFC0 - (64'($urandom_range(0, 2)) << 6);
                    else if (k == 9) prev = (64'($urandom_range(0, 15)) << 12) + (64'($urandom_range(0, 63)) << 6);
                end
                addrs.push_back(prev);
            end
            model(addrs, mbl, exp_q);
            foreach (addrs[i]) src_q.push_back(addrs[i]);
            drive_src();
            rand_sink = 1'b1;
            drain($sformatf("rnd%0d", r), 3000);
            compare_bursts($sformatf("rnd%0d", r), exp_q);
            check($sformatf("rnd%0d_beats", r), 72'(num_beats), 72'(addrs.size()));
            check($sformatf("rnd%0d_bursts", r), 72'(num_bursts), 72'(exp_q.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
